// File: rtl/mod_param_scheduler_if.sv
// Shadow-register write/commit port of the parameter scheduler.
// The slave samples strobes only while o_wr_ready is high; the master drives the strobes.
interface mod_param_scheduler_if;
    logic        i_wr_en;
    logic [2:0]  i_wr_addr;
    logic [31:0] i_wr_data;
    logic        i_commit;
    logic        o_wr_ready;

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_commit,
        input  o_wr_ready
    );

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_commit,
        output o_wr_ready
    );
endinterface

// File: rtl/mod_param_scheduler.sv
// Glitch-free modulation parameter update: shadows -> commit buffer -> active set applied at a half-period boundary or timeout.
// Active outputs change 2 edges after the boundary-detect cycle; o_wr_ready drops in PEND/APPLY, where strobes are ignored.
module mod_param_scheduler #(
    parameter int          OUTPUT_BIT  = 16,
    parameter logic [31:0] TIMEOUT_CYC = 32'd4096
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_mod_status,
    mod_param_scheduler_if.slave  wr_if,
    output logic [31:0]           o_freq_cnt,
    output logic [OUTPUT_BIT-1:0] o_amp_H,
    output logic [OUTPUT_BIT-1:0] o_amp_L,
    output logic [31:0]           o_ramp_trig_cnt,
    output logic                  o_mod_rst_n,
    output logic                  o_err,
    output logic                  o_timeout,
    output logic [1:0]            o_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PEND  = 2'd2,
        APPLY = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0]           freq;
        logic [OUTPUT_BIT-1:0] amp_h;
        logic [OUTPUT_BIT-1:0] amp_l;
        logic [31:0]           ramp;
    } param_t;

    localparam param_t RST_P = '{freq: 32'd125, amp_h: '0, amp_l: '0, ramp: '0};

    state_t      state_q, state_d;
    logic        rdy_q, rdy_d;
    logic        status_q, status_d;
    logic [31:0] cnt_q, cnt_d;
    param_t      shd_q, shd_d;
    param_t      buf_q, buf_d;
    param_t      act_q, act_d;
    logic        err_q, err_d;
    logic        tmo_q, tmo_d;

    param_t      eff;
    logic        ready;
    logic        wr_ok;
    logic        cm_ok;
    logic        cm_valid;
    logic        boundary;

    assign ready    = rdy_q && (state_q == IDLE || state_q == RUN);
    assign wr_ok    = wr_if.i_wr_en && ready;
    assign cm_ok    = wr_if.i_commit && ready;
    assign boundary = i_mod_status ^ status_q;

    always_comb begin
        state_d  = state_q;
        rdy_d    = 1'b1;
        status_d = i_mod_status;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        act_d    = act_q;
        err_d    = 1'b0;
        tmo_d    = 1'b0;
        eff      = shd_q;

        // Same-cycle write is folded in so a simultaneous commit sees it.
        if (wr_ok) begin
            case (wr_if.i_wr_addr)
                3'd0:    eff.freq  = wr_if.i_wr_data;
                3'd1:    eff.amp_h = wr_if.i_wr_data[OUTPUT_BIT-1:0];
                3'd2:    eff.amp_l = wr_if.i_wr_data[OUTPUT_BIT-1:0];
                3'd3:    eff.ramp  = wr_if.i_wr_data;
                default: err_d     = 1'b1;
            endcase
        end
        shd_d = eff;

        cm_valid = cm_ok && (eff.freq != 32'd0);
        if (cm_ok && eff.freq == 32'd0) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cm_valid) act_d = eff;
                if (i_enable) state_d = RUN;
            end
            RUN: begin
                if (!i_enable) begin
                    state_d = IDLE;
                    if (cm_valid) act_d = eff;
                end else if (cm_valid) begin
                    buf_d   = eff;
                    cnt_d   = 32'd0;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (boundary || !i_enable) begin
                    state_d = APPLY;
                end else if (cnt_q == TIMEOUT_CYC - 32'd1) begin
                    state_d = APPLY;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            APPLY: begin
                act_d   = buf_q;
                cnt_d   = 32'd0;
                state_d = i_enable ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            rdy_q    <= 1'b0;
            status_q <= 1'b0;
            cnt_q    <= 32'd0;
            shd_q    <= RST_P;
            buf_q    <= RST_P;
            act_q    <= RST_P;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= rdy_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            shd_q    <= shd_d;
            buf_q    <= buf_d;
            act_q    <= act_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    assign wr_if.o_wr_ready = ready;
    assign o_freq_cnt       = act_q.freq;
    assign o_amp_H          = act_q.amp_h;
    assign o_amp_L          = act_q.amp_l;
    assign o_ramp_trig_cnt  = act_q.ramp;
    assign o_mod_rst_n      = (state_q != IDLE);
    assign o_err            = err_q;
    assign o_timeout        = tmo_q;
    assign o_state          = state_q;

endmodule

// File: doc/mod_param_scheduler.md
MOD_PARAM_SCHEDULER -- requirements
Module: mod_param_scheduler

Interface
REQ-001 The block SHALL have parameter OUTPUT_BIT, default 16, giving the amplitude width.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 32'd4096, giving the maximum cycles a pending commit waits for a modulation boundary.
REQ-003 Port i_clk  input  1  system clock; all logic on its rising edge.
REQ-004 Port i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port i_enable  input  1  level; 1 = run the modulation generator, 0 = hold it in reset.
REQ-006 Port i_wr_en  input  1  one-cycle shadow-register write strobe.
REQ-007 Port i_wr_addr  input  3  shadow address: 0 freq_cnt, 1 amp_H, 2 amp_L, 3 ramp_trig_cnt, 4-7 invalid.
REQ-008 Port i_wr_data  input  32  write data; amplitudes take bits [OUTPUT_BIT-1:0].
REQ-009 Port i_commit  input  1  one-cycle request to copy shadows to active outputs.
REQ-010 Port i_mod_status  input  1  high/low half-period status from the modulation generator.
REQ-011 Port o_wr_ready  output  1  1 when writes and commits are accepted.
REQ-012 Port o_freq_cnt  output  32  active half-period count.
REQ-013 Port o_amp_H, o_amp_L  output  OUTPUT_BIT each  active high/low amplitudes.
REQ-014 Port o_ramp_trig_cnt  output  32  active step-trigger divider.
REQ-015 Port o_mod_rst_n  output  1  active-low reset to the modulation generator.
REQ-016 Port o_err  output  1  one-cycle pulse on an invalid write or rejected commit.
REQ-017 Port o_timeout  output  1  one-cycle pulse when a commit is applied by timeout.
REQ-018 Port o_state  output  2  current state: 0 IDLE, 1 RUN, 2 PEND, 3 APPLY.

Function
REQ-019 A write with o_wr_ready=1 SHALL update the addressed shadow on the next edge; addresses 4-7 SHALL leave all shadows unchanged and pulse o_err.
REQ-020 Writes and commits arriving while o_wr_ready=0 SHALL be ignored with no o_err.
REQ-021 If a write and a commit occur in the same cycle, the commit SHALL use the shadow value including that write.
REQ-022 A commit with an effective shadow freq_cnt of 0 SHALL be rejected: o_err pulses, outputs and state are unchanged.
REQ-023 IDLE: o_mod_rst_n=0 and o_wr_ready=1; a valid commit SHALL update the active outputs on the next edge.
REQ-024 IDLE -> RUN SHALL occur on the edge after i_enable=1 is sampled; o_mod_rst_n=1 in RUN, PEND and APPLY.
REQ-025 RUN: o_wr_ready=1; a valid commit SHALL move to PEND and latch the effective shadows into a commit buffer.
REQ-026 PEND: o_wr_ready=0; a boundary is i_mod_status differing from its one-cycle-registered copy; on a boundary, go to APPLY.
REQ-027 PEND SHALL count its cycles; at count TIMEOUT_CYC with no boundary it SHALL go to APPLY and pulse o_timeout.
REQ-028 APPLY SHALL last one cycle, copying the commit buffer to all four active outputs simultaneously, then return to RUN.
REQ-029 Latency: active outputs SHALL change exactly 2 edges after the boundary-detect cycle; no output SHALL ever show a mix of old and new parameters.
REQ-030 i_enable=0 sampled in RUN SHALL go to IDLE; in PEND it SHALL go to APPLY and then IDLE instead of RUN, so the pending commit is not lost.
REQ-031 The registered status copy SHALL track i_mod_status in all states, so no false boundary is detected on entry to PEND.

Reset
REQ-032 While i_rst_n=0: state IDLE, o_mod_rst_n=0, o_wr_ready=0, o_err=0, o_timeout=0, o_freq_cnt=shadow freq=32'd125, amplitudes and ramp_trig_cnt (active and shadow)=0, timeout counter=0.
REQ-033 o_wr_ready SHALL rise on the first edge after reset release; a reset asserted mid-PEND SHALL discard the pending commit.

Verification
REQ-034 In IDLE, write addr0=100, addr1=0x1000, addr2=0xF000, then commit -> next edge o_freq_cnt=100, o_amp_H=0x1000, o_amp_L=0xF000; o_mod_rst_n stays 0.
REQ-035 In RUN, write amp_H=0x2000 and commit; toggle i_mod_status 10 cycles later -> o_amp_H=0x2000 exactly 2 edges after the toggle is detected, o_wr_ready=0 throughout PEND.
REQ-036 With TIMEOUT_CYC=16, commit in RUN with i_mod_status held constant -> APPLY after 16 PEND cycles, one o_timeout pulse, new values active.
REQ-037 Commit with shadow freq_cnt=0, and a write to addr 5 -> each gives one o_err pulse; active outputs and state are unchanged.
REQ-038 Drop i_enable during PEND -> sequence APPLY, IDLE; new values active and o_mod_rst_n=0; assert i_rst_n=0 mid-PEND on a rerun -> all outputs return to their reset values.
